// File: rtl/sram_wr_ctrl_pkg.sv
// Shared constants and FSM state type for the TFT frame-buffer write path.
package tft_pkg;
  localparam int H_RES_DEF  = 480;
  localparam int V_RES_DEF  = 272;
  localparam int ADDR_W_DEF = 17;
  localparam int FB_WORDS   = H_RES_DEF * V_RES_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } wr_state_e;
endpackage

// File: rtl/sram_wr_ctrl_if.sv
// Write-port bundle between the frame-buffer write controller and the SRAM arbiter.
interface sram_wr_ctrl_if #(
  parameter int ADDR_W = 17
);
  // o_mem_req rises with o_mem_addr/o_mem_wdata valid and holds all three stable until
  // i_mem_ack; the ack is a one-cycle pulse and the request drops on the edge that sees it.
  logic              o_mem_req;
  logic              i_mem_ack;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [15:0]       o_mem_wdata;

  modport master (output o_mem_req, output o_mem_addr, output o_mem_wdata, input i_mem_ack);
  modport slave  (input o_mem_req, input o_mem_addr, input o_mem_wdata, output i_mem_ack);
endinterface

// File: rtl/sram_wr_ctrl_fifo.sv
// Small synchronous FIFO holding {address, pixel} words awaiting an SRAM write slot.
module pix_wr_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (i_push && !o_full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (i_pop && !o_empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full && !i_flush) mem_q[wr_ptr_q[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/sram_wr_ctrl.sv
// Frame-buffer write controller: window auto-increment addressing, pixel FIFO,
// req/ack write engine towards the SRAM arbiter, and full-frame clear.
module sram_wr_ctrl
  import tft_pkg::*;
#(
  parameter int          H_RES      = H_RES_DEF,
  parameter int          V_RES      = V_RES_DEF,
  parameter int          ADDR_W     = ADDR_W_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] CLR_DATA   = 16'h0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [15:0]           i_pixel_data,
  input  logic [31:0]           i_col_addr,
  input  logic [31:0]           i_row_addr,
  input  logic                  i_sram_clr_req,
  input  logic                  i_sram_write_req,
  input  logic                  i_sram_waddr_set_req,
  sram_wr_ctrl_if.master        mem,
  output logic                  o_busy,
  output logic                  o_drop,
  output wr_state_e             o_dbg_state
);
  localparam int FW = ADDR_W + 16;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  logic clr_prev_q, wr_prev_q, set_prev_q;
  logic clr_edge, wr_edge, set_edge;
  logic wr_evt_q;
  logic [15:0] pix_q;

  logic [15:0] xs_c, xe_c, ys_c, ye_c;
  logic [15:0] xs_q, xe_q, ys_q, ye_q, x_q, y_q;
  logic [ADDR_W-1:0] base_q, row0_q;

  wr_state_e state_q, state_d;
  logic req_q, req_d, clr_pend_q, clr_pend_d, drop_q;
  logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [15:0] wdata_q, wdata_d;

  logic push_ok, pop, flush, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_dout;

  assign clr_edge = i_sram_clr_req & ~clr_prev_q;
  assign wr_edge  = i_sram_write_req & ~wr_prev_q;
  assign set_edge = i_sram_waddr_set_req & ~set_prev_q;

  // Window coordinates are clamped to the panel and an inverted range collapses to its start.
  always_comb begin
    xs_c = (i_col_addr[31:16] > 16'(H_RES - 1)) ? 16'(H_RES - 1) : i_col_addr[31:16];
    xe_c = (i_col_addr[15:0]  > 16'(H_RES - 1)) ? 16'(H_RES - 1) : i_col_addr[15:0];
    ys_c = (i_row_addr[31:16] > 16'(V_RES - 1)) ? 16'(V_RES - 1) : i_row_addr[31:16];
    ye_c = (i_row_addr[15:0]  > 16'(V_RES - 1)) ? 16'(V_RES - 1) : i_row_addr[15:0];
    if (xs_c > xe_c) xe_c = xs_c;
    if (ys_c > ye_c) ye_c = ys_c;
  end

  assign push_ok = wr_evt_q && (state_q != ST_CLEAR) && !fifo_full;

  pix_wr_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (flush),
    .i_push  (push_ok),
    .i_din   ({base_q + ADDR_W'(x_q), pix_q}),
    .i_pop   (pop),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clr_prev_q <= 1'b0;
      wr_prev_q  <= 1'b0;
      set_prev_q <= 1'b0;
      wr_evt_q   <= 1'b0;
      pix_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      clr_prev_q <= i_sram_clr_req;
      wr_prev_q  <= i_sram_write_req;
      set_prev_q <= i_sram_waddr_set_req;
      wr_evt_q   <= wr_edge;
      if (wr_edge) pix_q <= i_pixel_data;
      if (wr_evt_q && ((state_q == ST_CLEAR) || fifo_full || flush)) drop_q <= 1'b1;
    end
  end

  // Pointer advances on every accepted or FIFO-full write; a window reload takes precedence.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      xs_q <= '0; xe_q <= '0; ys_q <= '0; ye_q <= '0;
      x_q  <= '0; y_q  <= '0;
      base_q <= '0; row0_q <= '0;
    end else if (set_edge) begin
      xs_q   <= xs_c; xe_q <= xe_c; ys_q <= ys_c; ye_q <= ye_c;
      x_q    <= xs_c; y_q  <= ys_c;
      base_q <= ADDR_W'(32'(ys_c) * H_RES);
      row0_q <= ADDR_W'(32'(ys_c) * H_RES);
    end else if (wr_evt_q && (state_q != ST_CLEAR)) begin
      if (x_q < xe_q) begin
        x_q <= x_q + 16'd1;
      end else begin
        x_q <= xs_q;
        if (y_q < ye_q) begin
          y_q    <= y_q + 16'd1;
          base_q <= base_q + ADDR_W'(H_RES);
        end else begin
          y_q    <= ys_q;
          base_q <= row0_q;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    clr_pend_d = clr_pend_q | clr_edge;
    pop        = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          flush      = 1'b1;
          clr_pend_d = clr_edge;
          cnt_d      = '0;
          req_d      = 1'b1;
          addr_d     = '0;
          wdata_d    = CLR_DATA;
          state_d    = ST_CLEAR;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          req_d   = 1'b1;
          addr_d  = fifo_dout[FW-1:16];
          wdata_d = fifo_dout[15:0];
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem.i_mem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (req_q) begin
          if (mem.i_mem_ack) begin
            req_d = 1'b0;
            if (clr_pend_q) begin
              cnt_d      = '0;
              clr_pend_d = clr_edge;
            end else if (cnt_q == LAST_ADDR) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + ADDR_W'(1);
            end
          end
        end else begin
          // A restart that arrives between clear writes begins again from address 0.
          req_d   = 1'b1;
          wdata_d = CLR_DATA;
          if (clr_pend_q) begin
            cnt_d      = '0;
            addr_d     = '0;
            clr_pend_d = clr_edge;
          end else begin
            addr_d = cnt_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign mem.o_mem_req   = req_q;
  assign mem.o_mem_addr  = addr_q;
  assign mem.o_mem_wdata = wdata_q;
  assign o_busy          = (state_q != ST_IDLE) || !fifo_empty || req_q || clr_pend_q;
  assign o_drop          = drop_q;
  assign o_dbg_state     = state_q;
endmodule

// File: tb/tb_sram_wr_ctrl.sv
// Directed bench for sram_wr_ctrl: window model predicts every committed write,
// a responder acks with programmable delay, and literal addresses pin the model.
module tb_sram_wr_ctrl;
  import tft_pkg::*;

  localparam int H  = 480;
  localparam int V  = 8;
  localparam int AW = 17;
  localparam int FB = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pix = '0;
  logic [31:0] col = '0, row = '0;
  logic        clr = 1'b0, wr = 1'b0, set = 1'b0;
  logic        busy, drop;
  wr_state_e   dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [AW+15:0] exp_q[$];
  logic [AW-1:0]  seen_addr[$];

  int m_xs = 0, m_xe = 0, m_ys = 0, m_ye = 0, m_x = 0, m_y = 0;
  bit m_drop = 1'b0;

  int ack_delay = 0;
  int wait_cnt  = 0;

  always #5 clk = ~clk;

  sram_wr_ctrl_if #(.ADDR_W(AW)) mem_if ();

  sram_wr_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .FIFO_DEPTH(4), .CLR_DATA(16'h0000)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_pixel_data         (pix),
    .i_col_addr           (col),
    .i_row_addr           (row),
    .i_sram_clr_req       (clr),
    .i_sram_write_req     (wr),
    .i_sram_waddr_set_req (set),
    .mem                  (mem_if),
    .o_busy               (busy),
    .o_drop               (drop),
    .o_dbg_state          (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_set(input int xs, input int xe, input int ys, input int ye);
    m_xs = clampv(xs, H - 1);
    m_xe = clampv(xe, H - 1);
    m_ys = clampv(ys, V - 1);
    m_ye = clampv(ye, V - 1);
    if (m_xs > m_xe) m_xe = m_xs;
    if (m_ys > m_ye) m_ye = m_ys;
    m_x = m_xs;
    m_y = m_ys;
  endtask

  task automatic model_write(input logic [15:0] d, input bit dropped);
    if (dropped) m_drop = 1'b1;
    else exp_q.push_back({AW'(m_y * H + m_x), d});
    if (m_x < m_xe) m_x++;
    else begin
      m_x = m_xs;
      m_y = (m_y < m_ye) ? m_y + 1 : m_ys;
    end
  endtask

  task automatic set_window(input int xs, input int xe, input int ys, input int ye);
    col = {16'(xs), 16'(xe)};
    row = {16'(ys), 16'(ye)};
    set = 1'b1;
    model_set(xs, xe, ys, ye);
    cyc(2);
    set = 1'b0;
    cyc(2);
  endtask

  task automatic write_pixel(input logic [15:0] d, input bit dropped);
    pix = d;
    wr  = 1'b1;
    model_write(d, dropped);
    cyc(2);
    wr = 1'b0;
    cyc(2);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    cyc(3);
    while (busy && n < budget) begin
      cyc(1);
      n++;
    end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL %s_timeout: o_busy still 1 after %0d cycles", name, budget);
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Arbiter model: one-cycle ack after ack_delay cycles of a request being visible.
  initial begin
    mem_if.i_mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      mem_if.i_mem_ack = 1'b0;
      if (mem_if.o_mem_req && rst_n) begin
        if (wait_cnt >= ack_delay) begin
          mem_if.i_mem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  logic           prev_req = 1'b0;
  logic [AW-1:0]  cur_addr = '0;
  logic [15:0]    cur_data = '0;
  logic [AW+15:0] exp_e;

  always @(negedge clk) begin
    if (mem_if.o_mem_req && !prev_req) begin
      seen_addr.push_back(mem_if.o_mem_addr);
      cur_addr = mem_if.o_mem_addr;
      cur_data = mem_if.o_mem_wdata;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0d data %0h with nothing expected",
                 mem_if.o_mem_addr, mem_if.o_mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_if.o_mem_addr), 32'(exp_e[AW+15:16]));
        check("wr_data", 32'(mem_if.o_mem_wdata), 32'(exp_e[15:0]));
      end
    end else if (mem_if.o_mem_req && prev_req) begin
      check("addr_stable", 32'(mem_if.o_mem_addr), 32'(cur_addr));
      check("data_stable", 32'(mem_if.o_mem_wdata), 32'(cur_data));
    end
    prev_req = mem_if.o_mem_req;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    cyc(3);
    check("rst_req", 32'(mem_if.o_mem_req), 0);
    check("rst_addr", 32'(mem_if.o_mem_addr), 0);
    check("rst_wdata", 32'(mem_if.o_mem_wdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    cyc(2);

    // Window auto-increment with row wrap and window wrap.
    ack_delay = 0;
    seen_addr.delete();
    set_window(10, 12, 5, 6);
    for (int i = 0; i < 7; i++) write_pixel(16'h1000 + 16'(i), 1'b0);
    wait_idle("t1", 200);
    check("t1_addr0", 32'(seen_addr[0]), 2410);
    check("t1_addr3", 32'(seen_addr[3]), 2890);
    check("t1_addr6", 32'(seen_addr[6]), 2410);
    check("t1_drop", 32'(drop), 32'(m_drop));

    // Clamping and inverted ranges.
    seen_addr.delete();
    set_window(500, 600, 2, 2);
    write_pixel(16'hA5A5, 1'b0);
    write_pixel(16'h5A5A, 1'b0);
    set_window(20, 5, 300, 1);
    write_pixel(16'h1234, 1'b0);
    write_pixel(16'h4321, 1'b0);
    wait_idle("t2", 200);
    check("t2_clamp_x", 32'(seen_addr[1]), 1439);
    check("t2_swap", 32'(seen_addr[3]), 3380);

    // Window load and write on the same edge.
    ack_delay = 5;
    seen_addr.delete();
    set_window(0, 4, 0, 0);
    write_pixel(16'h0F0F, 1'b0);
    col = {16'd3, 16'd3};
    row = {16'd3, 16'd3};
    pix = 16'hBEEF;
    set = 1'b1;
    wr  = 1'b1;
    model_set(3, 3, 3, 3);
    model_write(16'hBEEF, 1'b0);
    cyc(2);
    set = 1'b0;
    wr  = 1'b0;
    cyc(2);
    wait_idle("t3", 200);
    check("t3_same_edge", 32'(seen_addr[seen_addr.size() - 1]), 1443);

    // Slow arbiter: one in flight, four buffered, sixth discarded.
    ack_delay = 60;
    seen_addr.delete();
    set_window(100, 101, 1, 2);
    for (int i = 0; i < 6; i++) begin
      write_pixel(16'h2000 + 16'(i), i == 5);
      cyc(4);
    end
    check("t4_drop_set", 32'(drop), 32'(m_drop));
    wait_idle("t4", 1000);
    check("t4_addr4", 32'(seen_addr[4]), 580);
    ack_delay = 0;
    write_pixel(16'h2FFF, 1'b0);
    wait_idle("t4b", 200);
    check("t4_ptr_advanced", 32'(seen_addr[seen_addr.size() - 1]), 1060);
    check("t4_drop_sticky", 32'(drop), 32'(m_drop));

    // Clear while a write is in flight and another is queued.
    ack_delay = 60;
    seen_addr.delete();
    set_window(0, 1, 0, 0);
    write_pixel(16'hCAFE, 1'b0);
    write_pixel(16'hF00D, 1'b0);
    clr = 1'b1;
    cyc(2);
    clr = 1'b0;
    cyc(2);
    exp_q.delete();
    for (int i = 0; i < FB; i++) exp_q.push_back({AW'(i), 16'h0000});
    ack_delay = 0;
    cyc(6);
    check("t5_state_clear", 32'(dbg_state), 32'(ST_CLEAR));
    check("t5_busy", 32'(busy), 1);
    wait_idle("t5", 10000);
    check("t5_last_addr", 32'(seen_addr[seen_addr.size() - 1]), 3839);
    check("t5_write_count", 32'(seen_addr.size()), 3841);
    check("t5_drop", 32'(drop), 32'(m_drop));

    // Asynchronous reset while a request is outstanding.
    ack_delay = 1000;
    seen_addr.delete();
    set_window(7, 7, 1, 1);
    write_pixel(16'h7777, 1'b0);
    n = 0;
    while (!mem_if.o_mem_req && n < 50) begin
      cyc(1);
      n++;
    end
    check("t6_req_seen", 32'(mem_if.o_mem_req), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req_async", 32'(mem_if.o_mem_req), 0);
    check("t6_addr_async", 32'(mem_if.o_mem_addr), 0);
    check("t6_drop_async", 32'(drop), 0);
    exp_q.delete();
    m_drop = 1'b0;
    model_set(0, 0, 0, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check("t6_busy_after", 32'(busy), 0);
    ack_delay = 0;
    seen_addr.delete();
    write_pixel(16'h0101, 1'b0);
    wait_idle("t6", 200);
    check("t6_window_reset", 32'(seen_addr[0]), 0);
    check("t6_drop", 32'(drop), 32'(m_drop));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
